// File: rtl/btn_pkg.sv
// Shared button-handling definitions: FSM state encoding and ms-to-cycles conversion.
// Also imported by the LED drivers.
package btn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_DEB_PRESS   = 3'd1,
        ST_HELD        = 3'd2,
        ST_LONG_HELD   = 3'd3,
        ST_DEB_RELEASE = 3'd4
    } btn_state_t;

    // Divide first so large clock frequencies do not overflow 32 bits.
    function automatic logic [31:0] ms_to_cycles(input int unsigned clk_freq,
                                                 input int unsigned ms);
        return clk_freq / 1000 * ms;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= d;
            r_q    <= r_meta;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/button_press_counter.sv
// Debounced pushbutton: registered level, press and long-press strobes,
// and an 8-bit wrapping count of accepted presses.
module button_press_counter
    import btn_pkg::*;
#(
    parameter int unsigned CLK_FREQ      = 25_000_000,
    parameter int unsigned DEBOUNCE_MS   = 10,
    parameter int unsigned LONG_PRESS_MS = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn,
    output logic       btn_level,
    output logic       press_pulse,
    output logic       long_pulse,
    output logic [7:0] leds
);

    localparam logic [31:0] DEB_CYCLES  = ms_to_cycles(CLK_FREQ, DEBOUNCE_MS);
    localparam logic [31:0] LONG_CYCLES = ms_to_cycles(CLK_FREQ, LONG_PRESS_MS);
    localparam logic [31:0] DEB_LAST    = DEB_CYCLES - 32'd1;
    localparam logic [31:0] LONG_LAST   = LONG_CYCLES - 32'd1;

    if (DEB_CYCLES < 32'd1 || LONG_CYCLES <= DEB_CYCLES) begin : g_param_check
        $error("button_press_counter: need DEB_CYCLES >= 1 and LONG_CYCLES > DEB_CYCLES");
    end

    logic        w_sbtn;

    btn_state_t  r_state,    w_state;
    btn_state_t  r_src,      w_src;
    logic [31:0] r_deb_cnt,  w_deb_cnt;
    logic [31:0] r_hold_cnt, w_hold_cnt;
    logic        r_level,    w_level;
    logic        r_press,    w_press;
    logic        r_long,     w_long;
    logic [7:0]  r_leds,     w_leds;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn),
        .q   (w_sbtn)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_src      <= ST_IDLE;
            r_deb_cnt  <= '0;
            r_hold_cnt <= '0;
            r_level    <= 1'b0;
            r_press    <= 1'b0;
            r_long     <= 1'b0;
            r_leds     <= '0;
        end else begin
            r_state    <= w_state;
            r_src      <= w_src;
            r_deb_cnt  <= w_deb_cnt;
            r_hold_cnt <= w_hold_cnt;
            r_level    <= w_level;
            r_press    <= w_press;
            r_long     <= w_long;
            r_leds     <= w_leds;
        end
    end

    always_comb begin
        w_state    = r_state;
        w_src      = r_src;
        w_deb_cnt  = r_deb_cnt;
        w_hold_cnt = r_hold_cnt;
        w_level    = r_level;
        w_press    = 1'b0;
        w_long     = 1'b0;
        w_leds     = r_leds;

        case (r_state)
            ST_IDLE: begin
                if (w_sbtn) begin
                    w_state   = ST_DEB_PRESS;
                    w_deb_cnt = '0;
                end
            end
            ST_DEB_PRESS: begin
                if (!w_sbtn) begin
                    w_state = ST_IDLE;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state    = ST_HELD;
                    w_level    = 1'b1;
                    w_press    = 1'b1;
                    w_leds     = r_leds + 8'd1;
                    w_hold_cnt = '0;
                end else begin
                    w_deb_cnt = r_deb_cnt + 32'd1;
                end
            end
            ST_HELD: begin
                if (!w_sbtn) begin
                    w_state   = ST_DEB_RELEASE;
                    w_deb_cnt = '0;
                    w_src     = ST_HELD;
                end else if (r_hold_cnt == LONG_LAST) begin
                    w_state = ST_LONG_HELD;
                    w_long  = 1'b1;
                end else begin
                    w_hold_cnt = r_hold_cnt + 32'd1;
                end
            end
            ST_LONG_HELD: begin
                if (!w_sbtn) begin
                    w_state   = ST_DEB_RELEASE;
                    w_deb_cnt = '0;
                    w_src     = ST_LONG_HELD;
                end
            end
            ST_DEB_RELEASE: begin
                // A release glitch resumes the source state with hold_cnt untouched.
                if (w_sbtn) begin
                    w_state = r_src;
                end else if (r_deb_cnt == DEB_LAST) begin
                    w_state = ST_IDLE;
                    w_level = 1'b0;
                end else begin
                    w_deb_cnt = r_deb_cnt + 32'd1;
                end
            end
            default: begin
                w_state = ST_IDLE;
            end
        endcase
    end

    assign btn_level   = r_level;
    assign press_pulse = r_press;
    assign long_pulse  = r_long;
    assign leds        = r_leds;

endmodule

// File: tb/tb_button_press_counter.sv
// Directed bench for button_press_counter with DEB_CYCLES=4, LONG_CYCLES=20.
module tb_button_press_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn = 1'b0;
    logic       btn_level;
    logic       press_pulse;
    logic       long_pulse;
    logic [7:0] leds;

    int unsigned n_checks    = 0;
    int unsigned n_fail      = 0;
    int unsigned press_total = 0;
    int unsigned long_total  = 0;
    int unsigned base_p;
    int unsigned base_l;

    button_press_counter #(
        .CLK_FREQ      (1000),
        .DEBOUNCE_MS   (4),
        .LONG_PRESS_MS (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn         (btn),
        .btn_level   (btn_level),
        .press_pulse (press_pulse),
        .long_pulse  (long_pulse),
        .leds        (leds)
    );

    always #5 clk = ~clk;

    // Strobe counting and mutual-exclusion check, sampled mid-cycle.
    always @(negedge clk) begin
        if (press_pulse) press_total++;
        if (long_pulse)  long_total++;
        n_checks++;
        assert (!(press_pulse && long_pulse)) else begin
            n_fail++;
            $error("FAIL pulse_overlap: observed press=%b long=%b, required not both high",
                   press_pulse, long_pulse);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        btn = 1'b0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        rst = 1'b1;
        #1;
        check("rst_leds",  32'(leds), 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);
        check("rst_press", 32'(press_pulse), 32'd0);
        check("rst_long",  32'(long_pulse), 32'd0);
        tick(2);
        rst = 1'b0;
        tick(3);
        check("idle_leds", 32'(leds), 32'd0);

        // Clean press, 10 cycles held
        do_reset();
        base_p = press_total;
        base_l = long_total;
        btn = 1'b1;
        tick(6);
        check("t1_press_e6", 32'(press_pulse), 32'd0);
        check("t1_level_e6", 32'(btn_level), 32'd0);
        tick(1);
        check("t1_press_e7", 32'(press_pulse), 32'd1);
        check("t1_level_e7", 32'(btn_level), 32'd1);
        check("t1_leds_e7",  32'(leds), 32'd1);
        tick(1);
        check("t1_press_e8", 32'(press_pulse), 32'd0);
        tick(2);
        btn = 1'b0;
        tick(6);
        check("t1_level_e16", 32'(btn_level), 32'd1);
        tick(1);
        check("t1_level_e17", 32'(btn_level), 32'd0);
        check("t1_npress", press_total - base_p, 32'd1);
        check("t1_nlong",  long_total - base_l, 32'd0);
        check("t1_leds",   32'(leds), 32'd1);

        // Short bounces are discarded
        do_reset();
        base_p = press_total;
        for (int k = 0; k < 5; k++) begin
            btn = 1'b1;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                check("t2_level", 32'(btn_level), 32'd0);
            end
            btn = 1'b0;
            for (int j = 0; j < 3; j++) begin
                tick(1);
                check("t2_level", 32'(btn_level), 32'd0);
            end
        end
        tick(4);
        check("t2_npress", press_total - base_p, 32'd0);
        check("t2_leds",   32'(leds), 32'd0);

        // Long press held 40 cycles
        do_reset();
        base_p = press_total;
        base_l = long_total;
        btn = 1'b1;
        tick(7);
        check("t3_press_e7", 32'(press_pulse), 32'd1);
        tick(19);
        check("t3_long_e26", 32'(long_pulse), 32'd0);
        tick(1);
        check("t3_long_e27", 32'(long_pulse), 32'd1);
        check("t3_press_e27", 32'(press_pulse), 32'd0);
        tick(1);
        check("t3_long_e28", 32'(long_pulse), 32'd0);
        tick(12);
        btn = 1'b0;
        tick(12);
        check("t3_level", 32'(btn_level), 32'd0);
        check("t3_npress", press_total - base_p, 32'd1);
        check("t3_nlong",  long_total - base_l, 32'd1);
        check("t3_leds",   32'(leds), 32'd1);

        // 2-cycle release glitch while held; hold time resumes, not restarts
        do_reset();
        base_p = press_total;
        base_l = long_total;
        btn = 1'b1;
        tick(7);
        check("t4_press_e7", 32'(press_pulse), 32'd1);
        tick(3);
        btn = 1'b0;
        for (int j = 0; j < 2; j++) begin
            tick(1);
            check("t4_level_glitch", 32'(btn_level), 32'd1);
        end
        btn = 1'b1;
        for (int j = 0; j < 17; j++) begin
            tick(1);
            check("t4_level_held", 32'(btn_level), 32'd1);
        end
        check("t4_long_e29", 32'(long_pulse), 32'd0);
        tick(1);
        check("t4_long_e30", 32'(long_pulse), 32'd1);
        check("t4_npress", press_total - base_p, 32'd1);
        check("t4_leds",   32'(leds), 32'd1);
        btn = 1'b0;
        tick(12);
        check("t4_nlong", long_total - base_l, 32'd1);

        // 256 presses wrap the counter
        do_reset();
        base_p = press_total;
        base_l = long_total;
        for (int k = 0; k < 256; k++) begin
            btn = 1'b1;
            tick(8);
            btn = 1'b0;
            tick(8);
            if (k == 254) check("t5_leds_255", 32'(leds), 32'd255);
        end
        check("t5_leds_wrap", 32'(leds), 32'd0);
        check("t5_npress", press_total - base_p, 32'd256);
        check("t5_nlong",  long_total - base_l, 32'd0);

        // Asynchronous reset mid-DEB_PRESS and mid-HELD
        do_reset();
        base_p = press_total;
        btn = 1'b1;
        tick(8);
        btn = 1'b0;
        tick(12);
        check("t6_leds_pre", 32'(leds), 32'd1);
        btn = 1'b1;
        tick(4);
        #2;
        rst = 1'b1;
        #1;
        check("t6_deb_leds",  32'(leds), 32'd0);
        check("t6_deb_level", 32'(btn_level), 32'd0);
        check("t6_deb_press", 32'(press_pulse), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(7);
        check("t6_repress_e7", 32'(press_pulse), 32'd1);
        check("t6_repress_leds", 32'(leds), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t6_held_leds",  32'(leds), 32'd0);
        check("t6_held_level", 32'(btn_level), 32'd0);
        check("t6_held_press", 32'(press_pulse), 32'd0);
        check("t6_held_long",  32'(long_pulse), 32'd0);
        tick(1);
        rst = 1'b0;
        tick(6);
        check("t6_final_e6", 32'(press_pulse), 32'd0);
        tick(1);
        check("t6_final_e7", 32'(press_pulse), 32'd1);
        check("t6_final_leds", 32'(leds), 32'd1);
        tick(5);
        btn = 1'b0;
        tick(12);
        check("t6_leds_end",  32'(leds), 32'd1);
        check("t6_level_end", 32'(btn_level), 32'd0);
        check("t6_npress", press_total - base_p, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/button_press_counter.md
BUTTON_PRESS_COUNTER -- requirements
Module: button_press_counter

Interface
REQ-001 The block SHALL have a parameter CLK_FREQ, default 25_000_000, giving the clock frequency in Hz.
REQ-002 The block SHALL have a parameter DEBOUNCE_MS, default 10, giving the stable time in ms for a level change to be accepted.
REQ-003 The block SHALL have a parameter LONG_PRESS_MS, default 1000, giving the hold time in ms after press acceptance that flags a long press.
REQ-004 The block SHALL have the port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have the port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have the port btn, input, 1 bit: raw pushbutton, asynchronous to clk, 1 = pressed.
REQ-007 The block SHALL have the port btn_level, output, 1 bit: debounced button level.
REQ-008 The block SHALL have the port press_pulse, output, 1 bit: one-cycle strobe on each accepted press.
REQ-009 The block SHALL have the port long_pulse, output, 1 bit: one-cycle strobe when an accepted press reaches the long-press time.
REQ-010 The block SHALL have the port leds, output, 8 bits: count of accepted presses.

Function
REQ-011 btn SHALL pass through a 2-flop synchronizer; all other logic SHALL use only the synchronized value sbtn.
REQ-012 The block SHALL compute DEB_CYCLES = CLK_FREQ/1000*DEBOUNCE_MS and LONG_CYCLES = CLK_FREQ/1000*LONG_PRESS_MS; elaboration SHALL fail if DEB_CYCLES < 1 or LONG_CYCLES <= DEB_CYCLES.
REQ-013 The FSM SHALL have the states IDLE, DEB_PRESS, HELD, LONG_HELD and DEB_RELEASE; the counters are deb_cnt and hold_cnt, each 32 bits.
REQ-014 In IDLE with sbtn=1, the FSM SHALL go to DEB_PRESS with deb_cnt=0.
REQ-015 In DEB_PRESS with sbtn=0, the FSM SHALL return to IDLE with no output change; a bounce is discarded.
REQ-016 In DEB_PRESS with sbtn=1 and deb_cnt=DEB_CYCLES-1, the FSM SHALL go to HELD, set btn_level=1, pulse press_pulse, add 1 to leds and clear hold_cnt; otherwise it SHALL increment deb_cnt.
REQ-017 With a stable press, press_pulse SHALL be high for exactly one cycle, following clock edge DEB_CYCLES+3, counted from the first edge that samples btn=1.
REQ-018 leds SHALL wrap from 255 to 0 with no flag.
REQ-019 In HELD, hold_cnt SHALL increment each cycle; at hold_cnt=LONG_CYCLES-1 the FSM SHALL go to LONG_HELD and pulse long_pulse for one cycle.
REQ-020 From HELD or LONG_HELD with sbtn=0, the FSM SHALL go to DEB_RELEASE with deb_cnt=0 and SHALL record the source state.
REQ-021 In DEB_RELEASE with sbtn=1, the FSM SHALL return to the recorded source state; hold_cnt SHALL be held (not cleared) and no press_pulse SHALL occur.
REQ-022 In DEB_RELEASE with sbtn=0 and deb_cnt=DEB_CYCLES-1, the FSM SHALL go to IDLE with btn_level=0.
REQ-023 At most one long_pulse SHALL occur per accepted press.
REQ-024 press_pulse and long_pulse SHALL never be high in the same cycle.
REQ-025 All outputs SHALL be registered.

Reset
REQ-026 Asserting rst SHALL immediately force state=IDLE, clear both synchronizer flops and both counters, and set btn_level=0, press_pulse=0, long_pulse=0 and leds=8'h00.
REQ-027 A reset during any state SHALL abort that state with no strobe.
REQ-028 A press still held when rst is released SHALL be re-debounced from IDLE and counted once.

Structure
REQ-029 The state encoding (3-bit localparams) and the ms-to-cycles conversion function SHALL live in a shared package, btn_pkg, for reuse by the LED drivers.
REQ-030 The synchronizer SHALL be a separate sub-module, sync_2ff, with ports clk, rst, d and q; everything else SHALL be in one module.

Verification (parameters CLK_FREQ=1000, DEBOUNCE_MS=4, LONG_PRESS_MS=20, so DEB_CYCLES=4 and LONG_CYCLES=20)
REQ-031 A clean press held for 10 cycles, then released -> press_pulse for one cycle after edge 7, leds=1, btn_level=1 then 0, and no long_pulse.
REQ-032 A press of 3 cycles, followed by release and repeated 5 times -> no press_pulse, leds=0 and btn_level=0 throughout.
REQ-033 A press held for 40 cycles -> exactly one press_pulse, then exactly one long_pulse 20 cycles later, and leds=1.
REQ-034 While held, a 2-cycle release glitch -> btn_level stays 1, no extra press_pulse, and leds unchanged.
REQ-035 256 clean presses -> leds=0 after the last one, with 256 press_pulse strobes counted.
REQ-036 rst asserted mid-DEB_PRESS and mid-HELD, asynchronously and between edges -> outputs zero immediately, then a later clean press gives leds=1.
